// File: rtl/dds_pkg.sv
// Shared constants for the DDS waveform generator: waveform codes,
// midscale level and default datapath widths.
package dds_pkg;

    localparam int PHASE_W_DEF = 32;
    localparam int OUT_W_DEF   = 8;

    typedef enum logic [7:0] {
        WF_SINE     = 8'd0,
        WF_SQUARE   = 8'd1,
        WF_RAMP_UP  = 8'd2,
        WF_TRIANGLE = 8'd3,
        WF_RAMP_DN  = 8'd4
    } wf_e;

    localparam logic [7:0] MIDSCALE = 8'h80;

endpackage

// File: rtl/sine_qlut.sv
// Quarter-wave sine ROM: level = floor(127.5*sin(pi/2*(idx+0.5)/64)).
// The other three quadrants are derived by mirroring and offsetting.
module sine_qlut (
    input  logic [5:0] idx,
    output logic [6:0] level
);

    localparam logic [6:0] QUARTER_SINE [0:63] = '{
        7'd1,   7'd4,   7'd7,   7'd10,  7'd14,  7'd17,  7'd20,  7'd23,
        7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
        7'd50,  7'd53,  7'd55,  7'd58,  7'd61,  7'd64,  7'd66,  7'd69,
        7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
        7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
        7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
        7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
    };

    assign level = QUARTER_SINE[idx];

endmodule

// File: rtl/dds_wavegen.sv
// DDS waveform generator: debounced settings, 32-bit phase accumulator and a
// two-stage shaping pipeline producing an 8-bit DAC sample and a wrap pulse.
module dds_wavegen
    import dds_pkg::*;
#(
    parameter int PHASE_W       = PHASE_W_DEF,
    parameter int OUT_W         = OUT_W_DEF,
    parameter int STABLE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         wf,
    input  logic [PHASE_W-1:0] adder,
    output logic [OUT_W-1:0]   dac,
    output logic               sync,
    output logic [7:0]         wf_act
);

    localparam logic [7:0] STABLE_TARGET = 8'(STABLE_CYCLES);

    logic [7:0]         wf_prev;
    logic [PHASE_W-1:0] adder_prev;
    logic [PHASE_W-1:0] adder_act;
    logic [7:0]         stab_cnt;
    logic               match;
    logic               commit;

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] acc_sum;
    logic               wrap;

    logic [OUT_W-1:0]   p;
    logic [7:0]         wf_s1;
    logic               wrap_s1;
    logic [OUT_W-1:0]   shaped;
    logic [5:0]         sine_idx;
    logic [6:0]         sine_level;

    assign match  = (wf == wf_prev) && (adder == adder_prev);
    assign commit = (stab_cnt == STABLE_TARGET);
    assign {wrap, acc_sum} = {1'b0, acc} + {1'b0, adder_act};

    // Settings are adopted only after a run of identical samples, so the
    // byte-by-byte UART update of adder never leaks partial values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wf_prev    <= '0;
            adder_prev <= '0;
            stab_cnt   <= '0;
            adder_act  <= '0;
            wf_act     <= '0;
        end else begin
            wf_prev    <= wf;
            adder_prev <= adder;
            if (!match) begin
                stab_cnt <= '0;
            end else if (stab_cnt != STABLE_TARGET) begin
                stab_cnt <= stab_cnt + 8'd1;
            end
            if (commit) begin
                adder_act <= adder_prev;
                wf_act    <= wf_prev;
            end
        end
    end

    // The accumulator is never cleared on commit, keeping frequency steps
    // phase-continuous; the waveform code travels alongside the phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            p       <= '0;
            wf_s1   <= '0;
            wrap_s1 <= 1'b0;
            dac     <= MIDSCALE;
            sync    <= 1'b0;
        end else begin
            acc     <= acc_sum;
            p       <= acc[PHASE_W-1 -: OUT_W];
            wf_s1   <= wf_act;
            wrap_s1 <= wrap;
            dac     <= shaped;
            sync    <= wrap_s1;
        end
    end

    assign sine_idx = p[6] ? ~p[5:0] : p[5:0];

    sine_qlut u_sine_qlut (
        .idx   (sine_idx),
        .level (sine_level)
    );

    always_comb begin
        shaped = MIDSCALE;
        case (wf_s1)
            WF_SINE:     shaped = p[7] ? (8'd127 - {1'b0, sine_level})
                                       : (8'd128 + {1'b0, sine_level});
            WF_SQUARE:   shaped = p[7] ? 8'h00 : 8'hFF;
            WF_RAMP_UP:  shaped = p;
            WF_TRIANGLE: shaped = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
            WF_RAMP_DN:  shaped = ~p;
            default:     shaped = MIDSCALE;
        endcase
    end

endmodule

// File: tb/tb_dds_wavegen.sv
// Self-checking bench for dds_wavegen: directed scenarios plus randomized
// settings, compared every cycle against a history-based behavioural model.
module tb_dds_wavegen;

    localparam int S    = 16;
    localparam int HMAX = 16384;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  wf;
    logic [31:0] adder;
    logic [7:0]  dac;
    logic        sync;
    logic [7:0]  wf_act;

    int checks_total  = 0;
    int checks_passed = 0;

    // Model history, indexed by clock edges since the last reset.
    logic [31:0] acc_h   [HMAX];
    logic [31:0] act_h   [HMAX];
    logic [7:0]  wf_h    [HMAX];
    logic [39:0] samp_h  [HMAX];
    int          k = 0;
    bit          model_valid = 1'b0;

    logic [7:0]  sine_dac  [256];
    bit          sine_seen [256];

    dds_wavegen #(
        .PHASE_W       (32),
        .OUT_W         (8),
        .STABLE_CYCLES (S)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wf     (wf),
        .adder  (adder),
        .dac    (dac),
        .sync   (sync),
        .wf_act (wf_act)
    );

    always #5 clk = ~clk;

    function automatic int lut_val(int i);
        if (i == 63) return 127;
        return int'($floor(127.5 * $sin(3.14159265358979 * 0.5 * (real'(i) + 0.5) / 64.0)));
    endfunction

    function automatic logic [7:0] model_shape(int ph, int w);
        int q;
        int v;
        q = ph % 128;
        case (w)
            0: begin
                v = lut_val((q < 64) ? q : 127 - q);
                v = (ph < 128) ? 128 + v : 127 - v;
            end
            1:       v = (ph < 128) ? 255 : 0;
            2:       v = ph;
            3:       v = (ph < 128) ? 2 * q : 255 - 2 * q;
            4:       v = 255 - ph;
            default: v = 128;
        endcase
        return 8'(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("[TB] FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
    endtask

    // A setting is committed once S+1 identical samples end on the previous edge.
    task automatic modelUpdate();
        bit same;
        if (rst) begin
            k = 0;
            acc_h[0]  = '0;
            act_h[0]  = '0;
            wf_h[0]   = '0;
            samp_h[0] = '0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (k >= HMAX - 2) begin
                $display("[TB] FAIL model_history k=%0d actual=overflow required=room", k);
                $fatal(1, "[TB] history exhausted");
            end
            samp_h[k+1] = {wf, adder};
            acc_h[k+1]  = acc_h[k] + act_h[k];
            act_h[k+1]  = act_h[k];
            wf_h[k+1]   = wf_h[k];
            if (k >= S) begin
                same = 1'b1;
                for (int j = k - S; j < k; j++)
                    if (samp_h[j] != samp_h[k]) same = 1'b0;
                if (same) {wf_h[k+1], act_h[k+1]} = samp_h[k];
            end
            k++;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [7:0] w, input logic [31:0] a, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            rst   = r;
            wf    = w;
            adder = a;
            @(posedge clk);
            modelUpdate();
        end
    endtask

    // Per-cycle comparison of every output against the model history.
    always @(negedge clk) begin
        logic [7:0] e_dac;
        logic       e_sync;
        int         ph;
        int         pw;
        if (model_valid) begin
            if (k == 0) begin
                e_dac  = 8'h80;
                e_sync = 1'b0;
            end else if (k == 1) begin
                e_dac  = model_shape(0, 0);
                e_sync = 1'b0;
            end else begin
                ph = int'(acc_h[k-2][31:24]);
                pw = int'(wf_h[k-2]);
                e_dac  = model_shape(ph, pw);
                e_sync = (acc_h[k-1] < acc_h[k-2]);
                if (pw == 0) begin
                    sine_dac[ph]  = dac;
                    sine_seen[ph] = 1'b1;
                    if (ph == 0)   checkOutput("sine_p0",   dac, 32'd129);
                    if (ph == 63)  checkOutput("sine_p63",  dac, 32'd255);
                    if (ph == 64)  checkOutput("sine_p64",  dac, 32'd255);
                    if (ph == 191) checkOutput("sine_p191", dac, 32'd0);
                end
                if (pw == 3 && ph == 127) checkOutput("tri_p127", dac, 32'hFE);
                if (pw == 3 && ph == 128) checkOutput("tri_p128", dac, 32'hFF);
            end
            checkOutput("dac",    dac,    e_dac);
            checkOutput("sync",   sync,   e_sync);
            checkOutput("wf_act", wf_act, wf_h[k]);
        end
    end

    initial begin
        int bad;
        int pairs;
        int hold;
        logic [7:0]  rw;
        logic [31:0] ra;
        rst = 1'b1; wf = '0; adder = '0;
        applyStimulus(1'b1, 8'd0, 32'd0, 3);

        $display("[TB] ramp up, adder 2^24");
        applyStimulus(1'b0, 8'd2, 32'h0100_0000, 300);

        $display("[TB] byte-shifted adder sequence");
        applyStimulus(1'b0, 8'd2, 32'h0004_0000, 30);
        applyStimulus(1'b0, 8'd2, 32'h0000_0001, 5);
        applyStimulus(1'b0, 8'd2, 32'h0000_0100, 5);
        applyStimulus(1'b0, 8'd2, 32'h0001_0000, 5);
        applyStimulus(1'b0, 8'd2, 32'h0100_0000, 25);

        $display("[TB] sine period");
        for (int i = 0; i < 256; i++) sine_seen[i] = 1'b0;
        applyStimulus(1'b0, 8'd0, 32'h0100_0000, 300);
        bad = 0;
        pairs = 0;
        for (int i = 0; i < 128; i++) begin
            if (sine_seen[i] && sine_seen[i+128]) begin
                pairs++;
                if (int'(sine_dac[i]) + int'(sine_dac[i+128]) != 255) bad++;
            end
        end
        checkOutput("sine_coverage", pairs, 128);
        checkOutput("sine_symmetry", bad, 0);

        $display("[TB] square then triangle");
        applyStimulus(1'b0, 8'd1, 32'h0100_0000, 100);
        applyStimulus(1'b0, 8'd3, 32'h0100_0000, 300);

        $display("[TB] boundary increments");
        applyStimulus(1'b0, 8'd1, 32'h8000_0000, 40);
        applyStimulus(1'b0, 8'd7, 32'h8000_0000, 40);
        applyStimulus(1'b0, 8'd2, 32'hFFFF_FFFF, 40);
        applyStimulus(1'b0, 8'd4, 32'h0000_0000, 40);

        $display("[TB] reset during sine");
        applyStimulus(1'b0, 8'd0, 32'h0100_0000, 60);
        applyStimulus(1'b1, 8'd0, 32'h0100_0000, 1);
        applyStimulus(1'b0, 8'd0, 32'h0100_0000, 40);

        $display("[TB] randomized settings");
        for (int seg = 0; seg < 100; seg++) begin
            rw = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       ra = 32'($urandom);
                1:       ra = 32'($urandom_range(1, 255)) << 24;
                2:       ra = 32'($urandom_range(0, 65535));
                default: ra = 32'h8000_0000;
            endcase
            hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(15, 40);
            if ($urandom_range(0, 19) == 0) applyStimulus(1'b1, rw, ra, 1);
            applyStimulus(1'b0, rw, ra, hold);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
